// File: rtl/mc_bus_arbiter_if.sv
// Simple single-beat bus used on both sides of the arbiter.
// The master side drives the request and the slave side returns read data and ack.
interface mc_bus_arbiter_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/mc_bus_arbiter.sv
// Two-master round-robin arbiter that shares one memory port between the
// instruction bus and the data bus. It snapshots the winning request and
// routes the response back to that master. A watchdog ends any grant that the
// slave never acknowledges.
//
// state  | meaning
// IDLE   | no grant; pick a requester (tie goes to the master not served last)
// GNT_I  | ibus request on the memory port, watchdog counting
// GNT_D  | dbus request on the memory port, watchdog counting
// RESP   | one-cycle ack to the served master; requests ignored
module mc_bus_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   i_rst,
  mc_bus_arbiter_if.slave        ibus,
  mc_bus_arbiter_if.slave        dbus,
  mc_bus_arbiter_if.master       mem,
  output logic                   o_timeout,
  input  logic                   i_timeout_clr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  logic [1:0]       state_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0] mem_adr_q;
  logic [31:0] mem_dat_q;
  logic [3:0]  mem_sel_q;
  logic        mem_we_q;
  logic        mem_cyc_q;

  logic [31:0] ibus_rdt_q;
  logic [31:0] dbus_rdt_q;
  logic        ibus_ack_q;
  logic        dbus_ack_q;
  logic        timeout_q;

  logic in_grant;
  logic grant_d;
  logic grant_i;
  logic wd_fire;
  logic done;

  // The ibus is read-only; its write-side fields are never looked at.
  logic unused_ibus;
  assign unused_ibus = ^{ibus.dat, ibus.sel, ibus.we};

  assign in_grant = (state_q == GNT_I) || (state_q == GNT_D);
  // dbus wins when alone or on a tie after an ibus grant.
  assign grant_d  = (state_q == IDLE) && dbus.cyc && (!ibus.cyc || (last_q == LAST_I));
  assign grant_i  = (state_q == IDLE) && ibus.cyc && !grant_d;
  // An ack in the expiry cycle takes priority over the watchdog.
  assign wd_fire  = in_grant && !mem.ack && (cnt_q == CNT_TOP);
  assign done     = in_grant && (mem.ack || wd_fire);

  // Sequencing: arbitration, grant hold and the single response cycle.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= LAST_I;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q <= GNT_D;
            last_q  <= LAST_D;
            cnt_q   <= '0;
          end else if (grant_i) begin
            state_q <= GNT_I;
            last_q  <= LAST_I;
            cnt_q   <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (done) state_q <= RESP;
          else      cnt_q   <= cnt_q + CNT_W'(1);
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request snapshot: captured once at grant and frozen until the next grant.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      mem_adr_q <= '0;
      mem_dat_q <= '0;
      mem_sel_q <= '0;
      mem_we_q  <= 1'b0;
    end else if (grant_d) begin
      mem_adr_q <= dbus.adr;
      mem_dat_q <= dbus.dat;
      mem_sel_q <= dbus.sel;
      mem_we_q  <= dbus.we;
    end else if (grant_i) begin
      mem_adr_q <= ibus.adr;
      mem_dat_q <= '0;
      mem_sel_q <= 4'hF;
      mem_we_q  <= 1'b0;
    end
  end

  // Memory cycle strobe: rises with the grant, falls when the grant completes.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                   mem_cyc_q <= 1'b0;
    else if (grant_d || grant_i) mem_cyc_q <= 1'b1;
    else if (done)               mem_cyc_q <= 1'b0;
  end

  // Response routing: capture read data (zero on watchdog) and pulse the ack.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      ibus_rdt_q <= '0;
      dbus_rdt_q <= '0;
      ibus_ack_q <= 1'b0;
      dbus_ack_q <= 1'b0;
    end else begin
      ibus_ack_q <= done && (state_q == GNT_I);
      dbus_ack_q <= done && (state_q == GNT_D);
      if (done && (state_q == GNT_I)) ibus_rdt_q <= mem.ack ? mem.rdt : 32'h0;
      if (done && (state_q == GNT_D)) dbus_rdt_q <= mem.ack ? mem.rdt : 32'h0;
    end
  end

  // Sticky watchdog flag; a fire in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)              timeout_q <= 1'b0;
    else if (wd_fire)       timeout_q <= 1'b1;
    else if (i_timeout_clr) timeout_q <= 1'b0;
  end

  assign mem.adr   = mem_adr_q;
  assign mem.dat   = mem_dat_q;
  assign mem.sel   = mem_sel_q;
  assign mem.we    = mem_we_q;
  assign mem.cyc   = mem_cyc_q;
  assign ibus.rdt  = ibus_rdt_q;
  assign ibus.ack  = ibus_ack_q;
  assign dbus.rdt  = dbus_rdt_q;
  assign dbus.ack  = dbus_ack_q;
  assign o_timeout = timeout_q;

endmodule
